// File: rtl/updown_count_sequencer_pkg.sv
// Shared definitions for the up/down count sequencer: FSM state encoding and command modes.
package updown_count_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] MODE_SHORT = 2'b00;
   localparam logic [1:0] MODE_UP    = 2'b01;
   localparam logic [1:0] MODE_DOWN  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

endpackage

// File: rtl/updown_counter_core.sv
// WIDTH-bit up/down counter with parallel load; load wins over a step request.
module updown_counter_core #(
   parameter int WIDTH = 3
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             en,
   input  logic             M,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] Q
);

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         Q <= '0;
      end else if (load) begin
         Q <= d;
      end else if (en) begin
         Q <= M ? Q + WIDTH'(1) : Q - WIDTH'(1);
      end
   end

endmodule

// File: rtl/updown_count_sequencer.sv
// Walks the owned counter from its present value to a commanded target, paced by a prescaler.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | ready for a command; Q and M hold
//  ST_RUN  | stepping Q toward target once per STEP_DIV clocks
//  ST_DONE | target reached; done pulses for this single cycle
module updown_count_sequencer
   import updown_count_sequencer_pkg::*;
#(
   parameter int WIDTH    = 3,
   parameter int STEP_DIV = 1,
   parameter int DIV_W    = 8
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_target,
   input  logic [1:0]       cmd_mode,
   input  logic             abort,
   output logic [WIDTH-1:0] Q,
   output logic             M,
   output logic             busy,
   output logic             done,
   output logic             aborted
);

   localparam logic [DIV_W-1:0] RELOAD = DIV_W'(STEP_DIV - 1);

   state_t             state;
   logic [WIDTH-1:0]   target;
   logic [DIV_W-1:0]   prescale;
   logic [WIDTH-1:0]   d_up;
   logic [WIDTH-1:0]   d_dn;
   logic [WIDTH-1:0]   q_step;
   logic               accept;
   logic               step_en;
   logic               load_en;

   assign accept    = (state == ST_IDLE) && cmd_valid;
   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);

   // Modular distances; equal distance resolves to counting up.
   assign d_up   = cmd_target - Q;
   assign d_dn   = Q - cmd_target;
   assign q_step = M ? Q + WIDTH'(1) : Q - WIDTH'(1);

   assign step_en = (state == ST_RUN) && !abort && (prescale == '0);
   assign load_en = accept && (cmd_mode == MODE_LOAD);

   updown_counter_core #(.WIDTH(WIDTH)) u_core (
      .CLK  (CLK),
      .CLR  (CLR),
      .en   (step_en),
      .M    (M),
      .load (load_en),
      .d    (cmd_target),
      .Q    (Q)
   );

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state    <= ST_IDLE;
         target   <= '0;
         prescale <= '0;
         M        <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  target   <= cmd_target;
                  prescale <= RELOAD;
                  case (cmd_mode)
                     MODE_SHORT: M <= (d_up <= d_dn);
                     MODE_UP:    M <= 1'b1;
                     MODE_DOWN:  M <= 1'b0;
                     default:    M <= M;
                  endcase
                  if ((cmd_mode == MODE_LOAD) || (cmd_target == Q)) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state   <= ST_IDLE;
                  aborted <= 1'b1;
               end else if (prescale == '0) begin
                  prescale <= RELOAD;
                  if (q_step == target) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end
               end else begin
                  prescale <= prescale - DIV_W'(1);
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_updown_count_sequencer.sv
// Self-checking bench: a STEP_DIV=1 instance for direction/wrap/reset scenarios, a STEP_DIV=4 one for pacing/abort.
module tb_updown_count_sequencer;

   typedef struct packed {
      logic [2:0] q;
      logic       done;
   } exp_t;

   logic       clk = 1'b0;
   logic       clr = 1'b0;

   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_target = '0;
   logic [1:0] cmd_mode = '0;
   logic       abort = 1'b0;
   logic [2:0] q;
   logic       m, busy, done, aborted;

   logic       b_valid = 1'b0;
   logic       b_ready;
   logic [2:0] b_target = '0;
   logic [1:0] b_mode = '0;
   logic       b_abort = 1'b0;
   logic [2:0] b_q;
   logic       b_m, b_busy, b_done, b_aborted;

   int         checks = 0;
   int         errors = 0;
   exp_t       exp_q[$];
   logic [2:0] model_q = '0;
   logic       model_m = 1'b0;

   always #5 clk = ~clk;

   updown_count_sequencer #(.WIDTH(3), .STEP_DIV(1), .DIV_W(8)) dut (
      .CLK(clk), .CLR(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_target(cmd_target), .cmd_mode(cmd_mode), .abort(abort),
      .Q(q), .M(m), .busy(busy), .done(done), .aborted(aborted)
   );

   updown_count_sequencer #(.WIDTH(3), .STEP_DIV(4), .DIV_W(8)) dut4 (
      .CLK(clk), .CLR(clr), .cmd_valid(b_valid), .cmd_ready(b_ready),
      .cmd_target(b_target), .cmd_mode(b_mode), .abort(b_abort),
      .Q(b_q), .M(b_m), .busy(b_busy), .done(b_done), .aborted(b_aborted)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one command to dut, predicts every post-edge Q/done sample, then checks them in order.
   task automatic run_cmd(input logic [2:0] tgt, input logic [1:0] mode, input logic with_abort,
                          input string name);
      logic [2:0] d_up, d_dn;
      logic       exp_m;
      exp_t       e;
      bit         first;
      d_up = tgt - model_q;
      d_dn = model_q - tgt;
      case (mode)
         2'b00:   exp_m = (d_up <= d_dn);
         2'b01:   exp_m = 1'b1;
         2'b10:   exp_m = 1'b0;
         default: exp_m = model_m;
      endcase
      if (mode == 2'b11 || tgt == model_q) begin
         model_q = tgt;
         e.q = tgt; e.done = 1'b1;
         exp_q.push_back(e);
      end else begin
         e.q = model_q; e.done = 1'b0;
         exp_q.push_back(e);
         while (model_q != tgt) begin
            model_q = exp_m ? model_q + 3'd1 : model_q - 3'd1;
            e.q = model_q; e.done = (model_q == tgt);
            exp_q.push_back(e);
         end
      end
      model_m = exp_m;
      cmd_valid = 1'b1; cmd_target = tgt; cmd_mode = mode; abort = with_abort;
      tick();
      cmd_valid = 1'b0; abort = 1'b0;
      checks++;
      if (m !== exp_m) begin
         errors++;
         $display("FAIL %s dir: M=%0b expected %0b", name, m, exp_m);
      end
      first = 1'b1;
      while (exp_q.size() > 0) begin
         if (!first) tick();
         first = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if ({q, done, busy, cmd_ready} !== {e.q, e.done, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL %s step: Q=%0d done=%0b busy=%0b ready=%0b expected Q=%0d done=%0b busy=1 ready=0",
                     name, q, done, busy, cmd_ready, e.q, e.done);
         end
      end
      tick();
      checks++;
      if ({done, cmd_ready, q} !== {1'b0, 1'b1, model_q}) begin
         errors++;
         $display("FAIL %s end: done=%0b ready=%0b Q=%0d expected done=0 ready=1 Q=%0d",
                  name, done, cmd_ready, q, model_q);
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({q, m, busy, done, aborted, cmd_ready, b_q, b_ready} !== {3'd0, 4'b0000, 1'b1, 3'd0, 1'b1}) begin
         errors++;
         $display("FAIL reset: Q=%0d M=%0b busy=%0b done=%0b aborted=%0b ready=%0b bQ=%0d expected 0 0 0 0 0 1 0",
                  q, m, busy, done, aborted, cmd_ready, b_q);
      end
      @(negedge clk);
      clr = 1'b1;
      tick();
   endtask

   task automatic test_shortest();
      run_cmd(3'd3, 2'b00, 1'b0, "short_0_to_3");
   endtask

   task automatic test_wrap();
      run_cmd(3'd6, 2'b11, 1'b0, "load6");
      run_cmd(3'd1, 2'b00, 1'b0, "wrap_up_6_to_1");
      run_cmd(3'd6, 2'b00, 1'b0, "wrap_dn_1_to_6");
      checks++;
      if (m !== 1'b0) begin
         errors++;
         $display("FAIL wrap_dn_hold: M=%0b expected 0", m);
      end
      run_cmd(3'd0, 2'b11, 1'b0, "load0");
      run_cmd(3'd4, 2'b00, 1'b0, "tie_0_to_4");
      checks++;
      if (m !== 1'b1) begin
         errors++;
         $display("FAIL tie_dir: M=%0b expected 1", m);
      end
   endtask

   task automatic test_force_and_load();
      run_cmd(3'd2, 2'b11, 1'b0, "load2");
      run_cmd(3'd3, 2'b10, 1'b0, "force_dn_2_to_3");
      run_cmd(3'd5, 2'b11, 1'b0, "load5");
      checks++;
      if (q !== 3'd5) begin
         errors++;
         $display("FAIL load5_q: Q=%0d expected 5", q);
      end
   endtask

   task automatic test_zero_and_hold();
      run_cmd(3'd5, 2'b00, 1'b0, "zero_dist");
      run_cmd(3'd1, 2'b01, 1'b1, "abort_in_idle_accepted");
      run_cmd(3'd5, 2'b11, 1'b0, "reload5");
      cmd_valid = 1'b1; cmd_target = 3'd7; cmd_mode = 2'b00;
      tick();
      tick();
      checks++;
      if ({q, cmd_ready} !== {3'd6, 1'b0}) begin
         errors++;
         $display("FAIL hold_e1: Q=%0d ready=%0b expected Q=6 ready=0", q, cmd_ready);
      end
      tick();
      checks++;
      if ({q, done, cmd_ready} !== {3'd7, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL hold_e2: Q=%0d done=%0b ready=%0b expected Q=7 done=1 ready=0", q, done, cmd_ready);
      end
      tick();
      checks++;
      if ({busy, done, cmd_ready} !== {1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL hold_e3: busy=%0b done=%0b ready=%0b expected busy=0 done=0 ready=1", busy, done, cmd_ready);
      end
      tick();
      cmd_valid = 1'b0;
      checks++;
      if ({busy, done, q} !== {1'b1, 1'b1, 3'd7}) begin
         errors++;
         $display("FAIL hold_e4: busy=%0b done=%0b Q=%0d expected busy=1 done=1 Q=7", busy, done, q);
      end
      tick();
      model_q = 3'd7;
      model_m = 1'b1;
   endtask

   task automatic test_prescale();
      exp_t e;
      for (int k = 1; k <= 8; k++) begin
         e.q = 3'(k / 4);
         e.done = (k == 8);
         exp_q.push_back(e);
      end
      b_valid = 1'b1; b_target = 3'd2; b_mode = 2'b01;
      tick();
      b_valid = 1'b0;
      checks++;
      if ({b_m, b_busy, b_q} !== {1'b1, 1'b1, 3'd0}) begin
         errors++;
         $display("FAIL pre_accept: M=%0b busy=%0b Q=%0d expected 1 1 0", b_m, b_busy, b_q);
      end
      for (int k = 1; k <= 8; k++) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({b_q, b_done} !== {e.q, e.done}) begin
            errors++;
            $display("FAIL pre_edge%0d: Q=%0d done=%0b expected Q=%0d done=%0b", k, b_q, b_done, e.q, e.done);
         end
      end
      tick();
      b_valid = 1'b1; b_target = 3'd0; b_mode = 2'b11;
      tick();
      b_valid = 1'b0;
      tick();
      b_valid = 1'b1; b_target = 3'd2; b_mode = 2'b01;
      tick();
      b_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if ({b_q, b_done, b_aborted} !== {3'(k / 4), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_run_edge%0d: Q=%0d done=%0b aborted=%0b expected Q=%0d done=0 aborted=0",
                     k, b_q, b_done, b_aborted, k / 4);
         end
      end
      b_abort = 1'b1;
      tick();
      b_abort = 1'b0;
      checks++;
      if ({b_q, b_aborted, b_done, b_busy, b_ready} !== {3'd1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL abort_edge5: Q=%0d aborted=%0b done=%0b busy=%0b ready=%0b expected 1 1 0 0 1",
                  b_q, b_aborted, b_done, b_busy, b_ready);
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if ({b_q, b_aborted, b_done} !== {3'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_after%0d: Q=%0d aborted=%0b done=%0b expected Q=1 aborted=0 done=0",
                     k, b_q, b_aborted, b_done);
         end
      end
   endtask

   task automatic test_clr_mid_run();
      run_cmd(3'd0, 2'b11, 1'b0, "load0_pre_clr");
      cmd_valid = 1'b1; cmd_target = 3'd6; cmd_mode = 2'b01;
      tick();
      cmd_valid = 1'b0;
      tick(); tick(); tick();
      checks++;
      if ({q, busy} !== {3'd3, 1'b1}) begin
         errors++;
         $display("FAIL clr_pre: Q=%0d busy=%0b expected Q=3 busy=1", q, busy);
      end
      #2 clr = 1'b0;
      #1;
      checks++;
      if ({q, busy, cmd_ready, m, done} !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL clr_mid: Q=%0d busy=%0b ready=%0b M=%0b done=%0b expected 0 0 1 0 0",
                  q, busy, cmd_ready, m, done);
      end
      model_q = 3'd0;
      model_m = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      tick();
      run_cmd(3'd2, 2'b00, 1'b0, "after_clr");
   endtask

   initial begin
      test_reset();
      test_shortest();
      test_wrap();
      test_force_and_load();
      test_zero_and_hold();
      test_prescale();
      test_clr_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
